tx_scheduler: RTL and testbench
===============================

// Module: tx_scheduler
// PURPOSE
//  Round-robin transmit scheduler in front of the optical Encoder. Arbitrates N_REQ byte
//  requesters, latches the winner's byte, drives the Encoder's data/start, waits on avail,
//  then enforces an inter-packet idle gap. Sits between packet sources and Encoder
//  (replaces the tied-high start).
// PARAMETERS
//  N_PKT    8     bits per packet; matches Encoder N_PKT
//  N_REQ    4     number of requesters (>=2)
//  GAP_CT   10000 idle clk cycles between one packet's avail-return and the next start (>=1)
//  WDOG_CT  2**20 watchdog limit in cycles; used only with TX_WDOG_EN
// PORTS
//  clk        in  1            system clock (50 MHz)
//  rst        in  1            asynchronous, active-high reset
//  req_valid  in  N_REQ        requester i has a byte pending; hold until req_grant[i]
//  req_data   in  N_REQ*N_PKT  bytes; requester i at [i*N_PKT +: N_PKT]; stable while valid
//  req_grant  out N_REQ        one-hot, 1-cycle pulse: byte of requester i consumed
//  enc_data   out N_PKT        byte to Encoder; held stable from LAUNCH to end of WAIT_DONE
//  enc_start  out 1            1-cycle start pulse to Encoder
//  enc_avail  in  1            Encoder idle / ready for a new packet
//  busy       out 1            high in every state except IDLE
//  cur_src    out IDX_W        index of requester being sent (IDX_W = max(1,$clog2(N_REQ)))
//  wdog_err   out 1            1-cycle pulse on watchdog expiry (0 when TX_WDOG_EN undefined)
// BEHAVIOUR
//  Reset: every output 0; state IDLE; rr pointer = N_REQ-1 (requester 0 wins first);
//  gap counter 0 (first packet may launch without a gap).
//  IDLE: if |req_valid && enc_avail: winner = first set req_valid scanning from ptr+1
//    modulo N_REQ. Latch enc_data <= winner's byte, cur_src <= winner, ptr <= winner.
//    -> LAUNCH. Otherwise stay.
//  LAUNCH (1 cycle): enc_start=1, req_grant[cur_src]=1. -> WAIT_ACCEPT.
//  WAIT_ACCEPT: wait for enc_avail==0 (Encoder took the packet). -> WAIT_DONE.
//  WAIT_DONE: wait for enc_avail==1. -> GAP, load gap counter = GAP_CT-1.
//  GAP: decrement each cycle; at 0 -> IDLE. Requests are sampled only in IDLE.
//  Latency: req_valid seen in IDLE -> enc_start exactly 1 cycle later (registered).
//  Arbitration: strict round-robin over valid requesters; winner gets lowest priority next
//  round; a single active requester wins every round. req_valid dropped without a grant is
//  legal; it is simply not selected.
//  enc_data and cur_src change only on the IDLE->LAUNCH edge.
//  Reset mid-packet: outputs clear immediately (async); no grant is issued for the aborted byte.
//  Gap counter width: $clog2(GAP_CT+1); ptr wraps N_REQ-1 -> 0.
// CONFIGURATION
//  TX_WDOG_EN defined: counter runs in WAIT_ACCEPT/WAIT_DONE, cleared on state entry.
//    Reaching WDOG_CT-1 pulses wdog_err for 1 cycle and goes to GAP; the granted byte is
//    lost, not retried.
//  TX_WDOG_EN undefined: no counter logic; wdog_err tied 0; waits are unbounded.
// STRUCTURE
//  Package tx_sched_pkg: state enum {IDLE,LAUNCH,WAIT_ACCEPT,WAIT_DONE,GAP}; IDX_W helper function.
//  Sub-module rr_arbiter (N): combinational req/ptr -> one-hot grant + index. Pointer
//  register stays in tx_scheduler.
// TESTING
//  1) Reset, req_valid=4'b0001, data0=8'hA5, enc_avail=1 -> enc_start and req_grant=0001
//     one cycle after; enc_data=A5; cur_src=0.
//  2) req_valid=4'b1111, Encoder model holding avail low for 100 cycles each, GAP_CT=10
//     -> grant order 0,1,2,3,0; start-to-start spacing >= 100+10+3 cycles.
//  3) req_valid=4'b0100 only -> requester 2 served on every packet; wdog_err stays 0.
//  4) Encoder model never drops avail after start -> scheduler stuck in WAIT_ACCEPT;
//     with TX_WDOG_EN and WDOG_CT=64, wdog_err pulses once at 64 cycles, then GAP, then IDLE.
//  5) Assert rst during WAIT_DONE -> all outputs 0 the same cycle; after release,
//     requester 0 wins first again.
//  6) enc_avail=0 in IDLE with req_valid=0010 -> no start or grant until avail rises;
//     start is 1 cycle after the rise.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared types and helpers for the transmit scheduler.
// Provides the FSM state enum and the requester-index width helper.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACCEPT,
    WAIT_DONE,
    GAP
  } state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_scheduler_if.sv
// tx_scheduler_if: requester bus plus Encoder handshake.
// master = scheduler side (grant, enc_*, status); slave = environment.
interface tx_scheduler_if #(
  parameter int N_PKT = 8,
  parameter int N_REQ = 4
) ();
  import tx_sched_pkg::*;

  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*N_PKT-1:0] req_data;
  logic [N_REQ-1:0]       req_grant;
  logic [N_PKT-1:0]       enc_data;
  logic                   enc_start;
  logic                   enc_avail;
  logic                   busy;
  logic [IW-1:0]          cur_src;
  logic                   wdog_err;

  modport master (
    input  req_valid, req_data, enc_avail,
    output req_grant, enc_data, enc_start,
    output busy, cur_src, wdog_err
  );

  modport slave (
    output req_valid, req_data, enc_avail,
    input  req_grant, enc_data, enc_start,
    input  busy, cur_src, wdog_err
  );

endinterface

// File: rtl/tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after ptr.
// Ports: req (valid vector), ptr (last winner) -> gnt one-hot, idx, any.
module rr_arbiter
  import tx_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin byte scheduler feeding the optical Encoder.
// Ports: clk, rst (async high), bus (tx_scheduler_if.master).
// Optional watchdog on the Encoder waits: define TX_WDOG_EN.
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int N_PKT   = 8,
  parameter int N_REQ   = 4,
  parameter int GAP_CT  = 10000,
  parameter int WDOG_CT = 2**20
) (
  input logic            clk,
  input logic            rst,
  tx_scheduler_if.master bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int GW = $clog2(GAP_CT + 1);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CT - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        src_q, src_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [N_PKT-1:0]     data_q, data_d;
  logic                 start_q, start_d;
  logic [N_REQ-1:0]     grant_q, grant_d;

  logic [N_REQ-1:0]     arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;

`ifdef TX_WDOG_EN
  localparam int WW = $clog2(WDOG_CT);
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          wdog_q, wdog_d;
  logic          in_wait;
  assign in_wait = (state_q == WAIT_ACCEPT) ||
                   (state_q == WAIT_DONE);
`else
  localparam int wdog_ct_unused = WDOG_CT;
`endif

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    gap_d   = gap_q;
    data_d  = data_q;
    start_d = 1'b0;
    grant_d = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any && bus.enc_avail) begin
          state_d = LAUNCH;
          data_d  = bus.req_data[int'(arb_idx)*N_PKT +: N_PKT];
          src_d   = arb_idx;
          ptr_d   = arb_idx;
          // start/grant are registered so they land in LAUNCH
          start_d = 1'b1;
          grant_d = arb_gnt;
        end
      end
      LAUNCH:      state_d = WAIT_ACCEPT;
      WAIT_ACCEPT: if (!bus.enc_avail) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.enc_avail) begin
          state_d = GAP;
          gap_d   = GAP_LD;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef TX_WDOG_EN
    wdog_d = 1'b0;
    wcnt_d = '0;
    // counter restarts whenever a wait state is (re)entered
    if (in_wait && state_d == state_q)
      wcnt_d = wcnt_q + 1'b1;
    if (in_wait && wcnt_q == WW'(WDOG_CT - 1)) begin
      state_d = GAP;
      gap_d   = GAP_LD;
      wdog_d  = 1'b1;
      wcnt_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      src_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      grant_q <= '0;
`ifdef TX_WDOG_EN
      wcnt_q  <= '0;
      wdog_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      start_q <= start_d;
      grant_q <= grant_d;
`ifdef TX_WDOG_EN
      wcnt_q  <= wcnt_d;
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign bus.req_grant = grant_q;
  assign bus.enc_data  = data_q;
  assign bus.enc_start = start_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cur_src   = src_q;
`ifdef TX_WDOG_EN
  assign bus.wdog_err  = wdog_q;
`else
  assign bus.wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: self-checking bench for tx_scheduler.
// Encoder and requesters are modelled here; arbitration has its own reference.
module tb_tx_scheduler;

  localparam int N_PKT   = 8;
  localparam int N_REQ   = 4;
  localparam int GAP_CT  = 10;
  localparam int WDOG_CT = 64;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   cyc;
  int   enc_mode;
  int   enc_hold;
  int   enc_cnt;
  bit   enc_pend;
  int   m_ptr;
  logic [N_REQ-1:0]       seen_valid;
  logic [N_REQ*N_PKT-1:0] seen_data;

  tx_scheduler_if #(.N_PKT(N_PKT), .N_REQ(N_REQ)) bus ();

  tx_scheduler #(
    .N_PKT   (N_PKT),
    .N_REQ   (N_REQ),
    .GAP_CT  (GAP_CT),
    .WDOG_CT (WDOG_CT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int p);
    int w;
    w = -1;
    for (int k = 1; k <= N_REQ; k++)
      if (w < 0 && v[(p + k) % N_REQ]) w = (p + k) % N_REQ;
    return w;
  endfunction

  // one clock; Encoder registers start, then holds avail low enc_hold cycles
  task automatic step();
    seen_valid = bus.req_valid;
    seen_data  = bus.req_data;
    @(posedge clk);
    #1;
    cyc++;
    if (enc_mode == 1) begin
      if (enc_cnt > 0) begin
        enc_cnt--;
        if (enc_cnt == 0) bus.enc_avail = 1'b1;
      end else if (enc_pend) begin
        bus.enc_avail = 1'b0;
        enc_cnt  = enc_hold;
        enc_pend = 1'b0;
      end
      if (bus.enc_start) enc_pend = 1'b1;
    end
  endtask

  task automatic init_inputs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.enc_avail = 1'b1;
    enc_mode = 0;
    enc_cnt  = 0;
    enc_pend = 1'b0;
    enc_hold = 1;
    m_ptr    = N_REQ - 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    init_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_start(input int lim, output bit ok);
    int t;
    step();
    t = 1;
    while (bus.enc_start !== 1'b1 && t < lim) begin
      step();
      t++;
    end
    ok = (bus.enc_start === 1'b1);
    if (!ok) begin
      n_chk++;
      $display("FAIL start_timeout no enc_start in %0d cycles", lim);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.enc_start, bus.req_grant, bus.enc_data,
         bus.cur_src, bus.wdog_err, bus.busy} !== '0)
      $display("FAIL reset_outputs start=%b grant=%b data=%h src=%0d wd=%b busy=%b want all 0",
               bus.enc_start, bus.req_grant, bus.enc_data,
               bus.cur_src, bus.wdog_err, bus.busy);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_first_packet();
    do_reset();
    bus.req_data = $urandom;
    bus.req_data[7:0] = 8'hA5;
    bus.req_valid = 4'b0001;
    step();
    n_chk++;
    if (bus.enc_start !== 1'b1)
      $display("FAIL first_start got %b want 1", bus.enc_start);
    else n_pass++;
    n_chk++;
    if (bus.req_grant !== 4'b0001)
      $display("FAIL first_grant got %b want 0001", bus.req_grant);
    else n_pass++;
    n_chk++;
    if (bus.enc_data !== 8'hA5)
      $display("FAIL first_data got %h want a5", bus.enc_data);
    else n_pass++;
    n_chk++;
    if (bus.cur_src !== 2'd0 || bus.busy !== 1'b1)
      $display("FAIL first_src src=%0d busy=%b want 0,1", bus.cur_src, bus.busy);
    else n_pass++;
    bus.req_valid = '0;
    step();
    n_chk++;
    if (bus.enc_start !== 1'b0 || bus.req_grant !== 4'b0000)
      $display("FAIL first_pulse start=%b grant=%b want 0,0000",
               bus.enc_start, bus.req_grant);
    else n_pass++;
    n_chk++;
    if (bus.enc_data !== 8'hA5)
      $display("FAIL first_hold data=%h want a5", bus.enc_data);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    int last;
    int exp;
    logic [N_REQ-1:0] eg;
    do_reset();
    enc_mode = 1;
    enc_hold = 100;
    bus.req_data  = $urandom;
    bus.req_valid = 4'b1111;
    last = 0;
    for (int p = 0; p < 5; p++) begin
      wait_start(400, ok);
      if (ok) begin
        exp = p % N_REQ;
        eg  = N_REQ'(1 << exp);
        n_chk++;
        if (int'(bus.cur_src) != exp || bus.req_grant !== eg)
          $display("FAIL rr_order pkt %0d src=%0d grant=%b want %0d,%b",
                   p, bus.cur_src, bus.req_grant, exp, eg);
        else n_pass++;
        n_chk++;
        if (bus.enc_data !== seen_data[exp*N_PKT +: N_PKT])
          $display("FAIL rr_data pkt %0d got %h want %h", p,
                   bus.enc_data, seen_data[exp*N_PKT +: N_PKT]);
        else n_pass++;
        if (p > 0) begin
          n_chk++;
          if (cyc - last < enc_hold + GAP_CT + 3 ||
              cyc - last > enc_hold + GAP_CT + 6)
            $display("FAIL rr_spacing pkt %0d got %0d want >= %0d",
                     p, cyc - last, enc_hold + GAP_CT + 3);
          else n_pass++;
        end
        last = cyc;
      end
    end
  endtask

  task automatic test_single_requester();
    bit ok;
    int wd;
    int t;
    do_reset();
    enc_mode = 1;
    bus.req_data  = $urandom;
    bus.req_valid = 4'b0100;
    wd = 0;
    for (int p = 0; p < 4; p++) begin
      enc_hold = $urandom_range(5, 20);
      step();
      if (bus.wdog_err) wd++;
      t = 1;
      while (bus.enc_start !== 1'b1 && t < 200) begin
        step();
        if (bus.wdog_err) wd++;
        t++;
      end
      ok = (bus.enc_start === 1'b1);
      n_chk++;
      if (!ok || bus.cur_src !== 2'd2 || bus.req_grant !== 4'b0100)
        $display("FAIL single_req pkt %0d start=%b src=%0d grant=%b want 1,2,0100",
                 p, bus.enc_start, bus.cur_src, bus.req_grant);
      else n_pass++;
    end
    n_chk++;
    if (wd != 0)
      $display("FAIL single_wdog pulses=%0d want 0", wd);
    else n_pass++;
  endtask

  task automatic test_stuck_encoder();
    bit ok;
    int first;
    int pulses;
    do_reset();
    enc_mode = 2;
    bus.req_data  = $urandom;
    bus.req_valid = 4'b0001;
    wait_start(10, ok);
    bus.req_valid = '0;
    first  = -1;
    pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (bus.wdog_err === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
`ifdef TX_WDOG_EN
    n_chk++;
    if (pulses != 1)
      $display("FAIL wdog_pulses got %0d want 1", pulses);
    else n_pass++;
    n_chk++;
    if (first < WDOG_CT || first > WDOG_CT + 2)
      $display("FAIL wdog_time got %0d want about %0d", first, WDOG_CT);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0)
      $display("FAIL wdog_idle busy=%b want 0", bus.busy);
    else n_pass++;
`else
    n_chk++;
    if (pulses != 0)
      $display("FAIL stuck_wdog pulses=%0d want 0", pulses);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b1)
      $display("FAIL stuck_busy busy=%b want 1", bus.busy);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    do_reset();
    enc_mode = 1;
    enc_hold = 50;
    bus.req_data  = $urandom;
    bus.req_valid = 4'b0110;
    wait_start(10, ok);
    n_chk++;
    if (bus.cur_src !== 2'd1)
      $display("FAIL mid_first src=%0d want 1", bus.cur_src);
    else n_pass++;
    bus.req_valid = '0;
    repeat (10) step();
    n_chk++;
    if (bus.busy !== 1'b1)
      $display("FAIL mid_busy busy=%b want 1", bus.busy);
    else n_pass++;
    #5;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.enc_start, bus.req_grant, bus.enc_data,
         bus.cur_src, bus.wdog_err, bus.busy} !== '0)
      $display("FAIL mid_reset start=%b grant=%b data=%h src=%0d busy=%b want all 0",
               bus.enc_start, bus.req_grant, bus.enc_data,
               bus.cur_src, bus.busy);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_inputs();
    bus.req_data  = $urandom;
    bus.req_valid = 4'b1111;
    step();
    n_chk++;
    if (bus.enc_start !== 1'b1 || bus.cur_src !== 2'd0 ||
        bus.req_grant !== 4'b0001)
      $display("FAIL mid_restart start=%b src=%0d grant=%b want 1,0,0001",
               bus.enc_start, bus.cur_src, bus.req_grant);
    else n_pass++;
  endtask

  task automatic test_avail_gate();
    int bad;
    do_reset();
    bus.enc_avail = 1'b0;
    bus.req_data  = $urandom;
    bus.req_valid = 4'b0010;
    bad = 0;
    repeat (20) begin
      step();
      if (bus.enc_start !== 1'b0 || bus.req_grant !== 4'b0000) bad++;
    end
    n_chk++;
    if (bad != 0)
      $display("FAIL gate_hold early starts/grants=%0d want 0", bad);
    else n_pass++;
    bus.enc_avail = 1'b1;
    step();
    n_chk++;
    if (bus.enc_start !== 1'b1 || bus.req_grant !== 4'b0010 ||
        bus.cur_src !== 2'd1)
      $display("FAIL gate_release start=%b grant=%b src=%0d want 1,0010,1",
               bus.enc_start, bus.req_grant, bus.cur_src);
    else n_pass++;
  endtask

  task automatic test_random_traffic();
    int exp;
    int pk;
    int spur;
    logic prev;
    logic [N_REQ-1:0] eg;
    do_reset();
    enc_mode = 1;
    enc_hold = $urandom_range(1, 8);
    bus.req_data = $urandom;
    pk   = 0;
    spur = 0;
    prev = 1'b0;
    repeat (2500) begin
      step();
      if (bus.enc_start === 1'b1) begin
        exp = rr_pick(seen_valid, m_ptr);
        eg  = (exp < 0) ? '0 : N_REQ'(1 << exp);
        n_chk++;
        if (exp < 0 || int'(bus.cur_src) != exp || bus.req_grant !== eg ||
            bus.enc_data !== seen_data[((exp < 0) ? 0 : exp)*N_PKT +: N_PKT])
          $display("FAIL rand_pick pkt %0d src=%0d grant=%b data=%h want %0d,%b",
                   pk, bus.cur_src, bus.req_grant, bus.enc_data, exp, eg);
        else n_pass++;
        if (exp >= 0) m_ptr = exp;
        pk++;
        enc_hold = $urandom_range(1, 8);
        if (prev) spur++;
      end else if (bus.req_grant !== '0) spur++;
      prev = bus.enc_start;
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_grant[i]) begin
          bus.req_valid[i] = 1'b0;
          bus.req_data[i*N_PKT +: N_PKT] = N_PKT'($urandom);
        end else if (!bus.req_valid[i] && $urandom_range(0, 9) < 3)
          bus.req_valid[i] = 1'b1;
      end
    end
    n_chk++;
    if (spur != 0)
      $display("FAIL rand_pulses stray start/grant=%0d want 0", spur);
    else n_pass++;
    n_chk++;
    if (pk < 20)
      $display("FAIL rand_throughput packets=%0d want >= 20", pk);
    else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    rst    = 1'b1;
    test_reset();
    test_first_packet();
    test_round_robin();
    test_single_requester();
    test_stuck_encoder();
    test_reset_mid_packet();
    test_avail_gate();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
